// File: rtl/pixel_word_packer.sv
// Packs four 8-bit pixels per 32-bit word, tracks frame position and queues
// words in a small FIFO presented on a valid/ready interface.
module pixel_word_packer #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        frame_start,
  output logic        in_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        frame_done,
  output logic        drop_err,
  output logic        align_err
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  logic [1:0]    lane_q, lane_d, lane_b_s;
  logic [XW-1:0] x_q, x_d, x_b_s;
  logic [YW-1:0] y_q, y_d, y_b_s;
  logic [23:0]   hold_q, hold_d, hold_b_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [32:0]   mem_d [FIFO_DEPTH];
  logic          frame_done_q, frame_done_d;
  logic          drop_err_q, drop_err_d;
  logic          align_err_q, align_err_d;

  logic accept_s, push_s, pop_s, last_pix_s, mid_frame_s;

  // in_ready looks only at registered fill level, never at word_ready
  assign in_ready   = !rst && (cnt_q < C_FULL);
  assign word_valid = (cnt_q != {CW{1'b0}});
  assign word_out   = word_valid ? mem_q[rd_ptr_q][32:1] : 32'h0000_0000;
  assign word_last  = word_valid ? mem_q[rd_ptr_q][0]    : 1'b0;
  assign frame_done = frame_done_q;
  assign drop_err   = drop_err_q;
  assign align_err  = align_err_q;

  // Packing, frame position and error tracking
  always_comb begin
    accept_s    = pix_valid && in_ready;
    mid_frame_s = (lane_q != 2'd0) || (x_q != {XW{1'b0}}) || (y_q != {YW{1'b0}});

    // frame_start clears position first so a coincident pixel lands as pixel 0
    if (frame_start) begin
      lane_b_s = 2'd0;
      x_b_s    = {XW{1'b0}};
      y_b_s    = {YW{1'b0}};
      hold_b_s = 24'h00_0000;
    end else begin
      lane_b_s = lane_q;
      x_b_s    = x_q;
      y_b_s    = y_q;
      hold_b_s = hold_q;
    end

    last_pix_s = (x_b_s == X_LAST) && (y_b_s == Y_LAST);
    push_s     = accept_s && (lane_b_s == 2'd3);

    lane_d       = lane_b_s;
    x_d          = x_b_s;
    y_d          = y_b_s;
    hold_d       = hold_b_s;
    frame_done_d = 1'b0;

    if (accept_s) begin
      lane_d = lane_b_s + 2'd1;
      case (lane_b_s)
        2'd0:    hold_d[23:16] = pix_in;
        2'd1:    hold_d[15:8]  = pix_in;
        2'd2:    hold_d[7:0]   = pix_in;
        default: hold_d        = hold_b_s;
      endcase
      if (x_b_s == X_LAST) begin
        x_d = {XW{1'b0}};
        if (y_b_s == Y_LAST) begin
          y_d          = {YW{1'b0}};
          lane_d       = 2'd0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_b_s + YW'(1);
        end
      end else begin
        x_d = x_b_s + XW'(1);
      end
    end else begin
      lane_d = lane_b_s;
    end

    drop_err_d  = drop_err_q  || (pix_valid && !in_ready);
    align_err_d = align_err_q || (frame_start && mid_frame_s);
  end

  // FIFO pointer, fill level and storage update
  always_comb begin
    pop_s    = word_valid && word_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {hold_b_s, pix_in, last_pix_s};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= 2'd0;
      x_q          <= {XW{1'b0}};
      y_q          <= {YW{1'b0}};
      hold_q       <= 24'h00_0000;
      cnt_q        <= {CW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
      align_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 33'h0_0000_0000;
      end
    end else begin
      lane_q       <= lane_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
      align_err_q  <= align_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer with an 8x2 frame and a 4-entry FIFO.
module tb_pixel_word_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        frame_start;
  logic        in_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic        frame_done;
  logic        drop_err;
  logic        align_err;

  int n_checks = 0;
  int n_errors = 0;

  pixel_word_packer #(
    .IMG_WIDTH (8),
    .IMG_HEIGHT(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .in_ready   (in_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .frame_done (frame_done),
    .drop_err   (drop_err),
    .align_err  (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic fs);
    pix_in      = v;
    pix_valid   = 1'b1;
    frame_start = fs;
    step();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check_val({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check_val({tag, "_word_out"},   word_out,            32'h0);
    check_val({tag, "_word_last"},  {31'd0, word_last},  32'd0);
    check_val({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check_val({tag, "_drop_err"},   {31'd0, drop_err},   32'd0);
    check_val({tag, "_align_err"},  {31'd0, align_err},  32'd0);
  endtask

  initial begin
    logic [31:0] exp_w;
    rst = 1'b1; pix_in = 8'h00; pix_valid = 1'b0; frame_start = 1'b0; word_ready = 1'b1;
    #2;
    check_reset_outputs("rst0");
    step();
    step();
    rst = 1'b0;
    #1;
    check_val("rst0_release_in_ready", {31'd0, in_ready}, 32'd1);

    // full 16-pixel frame with downstream always ready
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      if ((i % 4) == 3) begin
        exp_w = {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)};
        check_val($sformatf("frame_word%0d", i / 4), word_out, exp_w);
        check_val($sformatf("frame_valid%0d", i / 4), {31'd0, word_valid}, 32'd1);
        check_val($sformatf("frame_last%0d", i / 4), {31'd0, word_last}, (i == 15) ? 32'd1 : 32'd0);
      end else begin
        check_val($sformatf("frame_novalid_p%0d", i), {31'd0, word_valid}, 32'd0);
      end
      if (i >= 14) begin
        check_val($sformatf("frame_done_p%0d", i), {31'd0, frame_done}, (i == 15) ? 32'd1 : 32'd0);
      end
    end
    step();
    check_val("frame_done_single", {31'd0, frame_done}, 32'd0);
    check_val("frame_drained", {31'd0, word_valid}, 32'd0);

    // frame_start at a clean frame boundary is not an alignment error
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("fs_clean_align", {31'd0, align_err}, 32'd0);

    // packing order of a single word
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    check_val("pack_valid", {31'd0, word_valid}, 32'd1);
    check_val("pack_word", word_out, 32'h1020_3040);
    check_val("pack_last", {31'd0, word_last}, 32'd0);

    // mid-frame realign discards the partial word
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    check_val("realign_no_partial", {31'd0, word_valid}, 32'd0);
    send(8'h01, 1'b1);
    check_val("realign_align_err", {31'd0, align_err}, 32'd1);
    send(8'h02, 1'b0); send(8'h03, 1'b0);
    check_val("realign_no_early", {31'd0, word_valid}, 32'd0);
    send(8'h04, 1'b0);
    check_val("realign_valid", {31'd0, word_valid}, 32'd1);
    check_val("realign_word", word_out, 32'h0102_0304);
    step();
    check_val("realign_empty", {31'd0, word_valid}, 32'd0);

    // coincident push and pop with one word queued
    word_ready = 1'b0;
    send(8'h50, 1'b0); send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0);
    check_val("pp_first", word_out, 32'h5051_5253);
    send(8'h54, 1'b0); send(8'h55, 1'b0); send(8'h56, 1'b0);
    check_val("pp_stable", word_out, 32'h5051_5253);
    word_ready = 1'b1;
    send(8'h57, 1'b0);
    check_val("pp_valid", {31'd0, word_valid}, 32'd1);
    check_val("pp_second", word_out, 32'h5455_5657);
    step();
    check_val("pp_count_one", {31'd0, word_valid}, 32'd0);

    // backpressure: 20 pixels into a stalled 4-word FIFO
    word_ready = 1'b0;
    check_val("bp_drop_before", {31'd0, drop_err}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check_val($sformatf("bp_in_ready_p%0d", i), {31'd0, in_ready}, (i < 16) ? 32'd1 : 32'd0);
      send(8'(8'h80 + i), (i == 0) ? 1'b1 : 1'b0);
      if (i == 15 || i == 16) begin
        check_val($sformatf("bp_frame_done_p%0d", i), {31'd0, frame_done}, (i == 15) ? 32'd1 : 32'd0);
      end
    end
    check_val("bp_drop_err", {31'd0, drop_err}, 32'd1);
    check_val("bp_head_stable", word_out, 32'h8081_8283);
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = {8'(8'h80 + 4 * k), 8'(8'h81 + 4 * k), 8'(8'h82 + 4 * k), 8'(8'h83 + 4 * k)};
      check_val($sformatf("bp_drain_valid%0d", k), {31'd0, word_valid}, 32'd1);
      check_val($sformatf("bp_drain_word%0d", k), word_out, exp_w);
      check_val($sformatf("bp_drain_last%0d", k), {31'd0, word_last}, (k == 3) ? 32'd1 : 32'd0);
      step();
      if (k == 0) begin
        check_val("bp_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
      end
    end
    check_val("bp_drained", {31'd0, word_valid}, 32'd0);
    check_val("bp_drop_sticky", {31'd0, drop_err}, 32'd1);

    // reset with three words queued and a partial word at lane 2
    word_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      send(8'(8'hE0 + i), (i == 0) ? 1'b1 : 1'b0);
    end
    check_val("mid_queued", word_out, 32'hE0E1_E2E3);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    step();
    rst = 1'b0;
    #1;
    check_val("rst1_release_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst1_release_valid", {31'd0, word_valid}, 32'd0);
    word_ready = 1'b1;
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
    check_val("rst1_no_early", {31'd0, word_valid}, 32'd0);
    send(8'hC4, 1'b0);
    check_val("rst1_valid", {31'd0, word_valid}, 32'd1);
    check_val("rst1_word", word_out, 32'hC1C2_C3C4);
    check_val("rst1_last", {31'd0, word_last}, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Downstream collector for the 8-bit point-operation stage (brighten, darken, threshold, invert). It accepts one processed grayscale pixel per cycle and packs four consecutive pixels into a 32-bit word. Packed words are buffered in a small FIFO and presented on a valid/ready interface toward the frame store. The block also tracks frame position and flags frame boundaries and errors.

## Interface
- IMG_WIDTH, 256, pixels per line; must be a multiple of 4.
- IMG_HEIGHT, 256, lines per frame.
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, minimum 2.

- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_in  input  8  processed pixel from the point-op stage output register.
- pix_valid  input  1  pix_in carries a valid pixel this cycle.
- frame_start  input  1  one-cycle pulse that realigns packing to pixel 0 of a new frame.
- in_ready  output  1  block can accept a pixel this cycle.
- word_out  output  32  packed word: first pixel in [31:24], fourth pixel in [7:0].
- word_valid  output  1  word_out and word_last are valid.
- word_ready  input  1  downstream accepts the word this cycle.
- word_last  output  1  word_out is the final word of the frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
- drop_err  output  1  sticky: a pixel was dropped because in_ready was low.
- align_err  output  1  sticky: frame_start arrived mid-frame.

## Operation
- **Accept:** a pixel is accepted when pix_valid=1 and in_ready=1.
- **Drop:** if pix_valid=1 and in_ready=0, the pixel is discarded, drop_err is set, and no counter advances. The point-op stage cannot stall, so a drop is the only overflow response.
- **Packing:**
  - A 2-bit lane counter selects the byte slot: lane 0 goes to [31:24] and lane 3 goes to [7:0].
  - Lanes 0-2 write into a holding register.
  - Acceptance at lane 3 pushes {holding, pix_in, last} into the FIFO and returns the lane counter to 0.
- **Position:**
  - x counter runs 0..IMG_WIDTH-1; y counter runs 0..IMG_HEIGHT-1. Both advance on accept.
  - x wraps to 0 and increments y.
  - At x=IMG_WIDTH-1 and y=IMG_HEIGHT-1, the pushed word has last=1. x, y and lane all return to 0, and frame_done is registered high for the next cycle.
- **frame_start:**
  - Clears lane, x, y and the holding register. Any partial word is discarded and never pushed.
  - Sets align_err if lane, x or y was non-zero. Does not flush the FIFO.
  - If frame_start and an accepted pixel coincide, the clear applies first and the pixel is accepted as pixel 0 of the new frame.
- **FIFO:**
  - word_valid = not empty; word_out and word_last come from the FIFO head.
  - A pop occurs on word_valid & word_ready.
  - Simultaneous push and pop is legal at any fill level except full. When full, no push can occur because in_ready=0.
- **in_ready:** in_ready = !rst && count < FIFO_DEPTH. It depends only on registered state, with no combinational path from word_ready.
- **Sticky errors:** drop_err and align_err clear only on rst.

## Timing
- **Reset (asynchronous):**
  - in_ready=0 while rst=1, and 1 in the first cycle after release.
  - word_valid=0, word_out=0, word_last=0, frame_done=0, drop_err=0, align_err=0.
  - lane, x and y are 0; FIFO is empty.
  - Reset asserted mid-frame discards all buffered words and the partial word.
- **Latency:** a word is visible with word_valid=1 in the cycle after the edge that accepted its fourth pixel.
- **Throughput:** one pixel per cycle sustained, provided word_ready=1 at least one cycle in four.
- **Stability:** word_out and word_last hold stable while word_valid=1 and word_ready=0.
- **frame_done:** high for exactly one cycle, the cycle after the edge accepting the last pixel. This is the same cycle in which word_valid can first show the last word, if the FIFO was empty.
- **in_ready after a pop:** a pop at full raises in_ready in the following cycle.

## Test plan
- **Packing order, single word:** after reset, stream 0x10, 0x20, 0x30, 0x40 with word_ready=1.
  - word_out=0x10203040 and word_valid=1 one cycle after 0x40; word_last=0.
- **Full frame:** IMG_WIDTH=8, IMG_HEIGHT=2, stream pixels 0..15.
  - Four words 0x00010203 .. 0x0C0D0E0F are produced; only the last has word_last=1.
  - frame_done pulses once; x, y and lane are 0 afterwards.
- **Backpressure:** word_ready=0, FIFO_DEPTH=4, stream 20 pixels continuously.
  - in_ready drops after 16 pixels; pixels 17-20 are dropped; drop_err=1.
  - Raising word_ready drains exactly 4 words in order.
- **Mid-frame realign:** stream 0xAA, 0xBB, then pulse frame_start together with pixel 0x01, then send 0x02, 0x03, 0x04.
  - align_err=1; the next word is 0x01020304; no word contains 0xAA.
- **Reset mid-operation:** with 3 words queued and lane=2, assert rst for one cycle.
  - All outputs are zero, word_valid=0, and in_ready=0 during reset, then 1.
  - The next four pixels form the first word.
- **Push/pop coincident:** FIFO holds 1 word; word_ready=1 in the same cycle a fourth pixel completes a word.
  - Count stays 1; words emerge in order with no loss.
